// File: rtl/row_fetch_pkg.sv
// Shared types and constants for the row fetch serializer.
//   fetch_state_t : memory-side controller states
//   BYTE_W        : width of one streamed byte
package row_fetch_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    SEND
  } fetch_state_t;

endpackage

// File: rtl/word_serializer.sv
// Loads one memory word and streams it MSB byte first over a valid/ready link.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : clear byte counter (row start)
//   load      : capture word and begin streaming
//   word      : word to stream
//   ready     : downstream can accept
//   data      : current byte (top byte of shift register)
//   valid     : data is valid
//   last      : current byte is the final byte of the row
//   finish    : final byte transfers this cycle
module word_serializer
  import row_fetch_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int BYTES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              ready,
  output logic [BYTE_W-1:0] data,
  output logic              valid,
  output logic              last,
  output logic              finish
);

  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  byte_cnt;
  logic              xfer;

  assign data   = shreg[DATA_W-1 -: BYTE_W];
  assign last   = valid && (byte_cnt == CNT_W'(BYTES - 1));
  assign xfer   = valid && ready;
  assign finish = xfer && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
      valid    <= 1'b0;
    end else begin
      if (load) begin
        shreg <= word;
        valid <= 1'b1;
      end else if (xfer) begin
        shreg <= shreg << BYTE_W;
        if (last) valid <= 1'b0;
      end
      // The counter holds on the final byte so it never wraps inside a row.
      if (clear) begin
        byte_cnt <= '0;
      end else if (xfer && !last) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/row_fetch_serializer.sv
// Fetches one 64-bit matrix row over Avalon-MM and streams it as bytes into
// the MAC array FIFO, pulsing done when the row has gone out (err on timeout).
//
// state | meaning
// IDLE  | waiting for start
// REQ   | mem_read asserted, waiting for the slave to accept
// WAIT  | read accepted, waiting for readdatavalid (timeout counted)
// SEND  | streaming bytes through word_serializer
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start, row_addr       : row fetch request and its word address
//   busy, done, err       : status; done/err are single-cycle pulses
//   mem_*                 : Avalon-MM read master
//   out_data/valid/ready/last : byte stream to FIFO write port
module row_fetch_serializer #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 64,
  parameter int BYTES   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  import row_fetch_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT + 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [TO_W-1:0]   to_cnt;
  logic              done_q;
  logic              load;
  logic              clear;
  logic              ser_finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      to_cnt  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        addr_q <= row_addr;
        to_cnt <= '0;
      end else if (state_q == WAIT) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      done_q <= (state_q == SEND) && ser_finish;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_read = 1'b0;
    load     = 1'b0;
    clear    = 1'b0;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) begin
          // A zero-latency slave may return data in the accept cycle.
          if (mem_readdatavalid) begin
            load    = 1'b1;
            state_d = SEND;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Data arriving on the timeout cycle still wins.
        if (mem_readdatavalid) begin
          load    = 1'b1;
          state_d = SEND;
        end else if (to_cnt == TO_W'(TIMEOUT)) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      SEND: begin
        if (ser_finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_address = addr_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

  word_serializer #(
    .DATA_W (DATA_W),
    .BYTES  (BYTES)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .load   (load),
    .word   (mem_readdata),
    .ready  (out_ready),
    .data   (out_data),
    .valid  (out_valid),
    .last   (out_last),
    .finish (ser_finish)
  );

endmodule

// File: tb/tb_row_fetch_serializer.sv
module tb_row_fetch_serializer;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  row_addr;
  logic        busy, done, err;
  logic [3:0]  mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [63:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  row_fetch_serializer #(
    .ADDR_W  (4),
    .DATA_W  (64),
    .BYTES   (8),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .row_addr          (row_addr),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One row: optional start cycle, stall cycles of waitrequest, read latency
  // (0 = data in the accept cycle), optional 1,0,0 backpressure, and optional
  // chained start in the done cycle.
  task automatic run_row(input logic [3:0] addr, input logic [63:0] word,
                         input int stall, input int lat, input bit bp,
                         input bit do_start, input bit chain, input logic [3:0] next_addr);
    int k, sc, accepts, reads;
    logic [7:0] eb;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1; row_addr = addr;
      #1 check("idle_busy", busy, 0);
      @(negedge clk);
      start = 1'b0; row_addr = 4'hF;
    end
    accepts = 0; reads = 0;
    for (int c = 0; c <= stall; c++) begin
      mem_waitrequest   = (c < stall);
      mem_readdatavalid = (lat == 0 && c == stall);
      mem_readdata      = mem_readdatavalid ? word : 64'hA5A5_A5A5_A5A5_A5A5;
      #1;
      check("req_busy", busy, 1);
      check("req_addr", mem_address, addr);
      if (mem_read) reads++;
      if (mem_read && !mem_waitrequest) accepts++;
      @(negedge clk);
    end
    mem_waitrequest = 1'b0;
    check("req_read_cycles", reads, stall + 1);
    check("req_accepts", accepts, 1);
    for (int w = 1; w <= lat; w++) begin
      mem_readdatavalid = (w == lat);
      mem_readdata      = (w == lat) ? word : 64'h5A5A_5A5A_5A5A_5A5A;
      #1;
      check("wait_read", mem_read, 0);
      check("wait_valid", out_valid, 0);
      @(negedge clk);
    end
    k = 0; sc = 0;
    while (k < 8 && sc < 64) begin
      out_ready = bp ? (sc % 3 == 0) : 1'b1;
      start = bp;                       // ignored while busy
      mem_readdatavalid = bp;           // stray data outside REQ/WAIT
      mem_readdata = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      eb = word[63 - 8*k -: 8];
      check("send_valid", out_valid, 1);
      check("send_data", out_data, eb);
      check("send_last", out_last, (k == 7));
      if (out_valid && out_ready) k++;
      sc++;
      @(negedge clk);
    end
    start = 1'b0; mem_readdatavalid = 1'b0; out_ready = 1'b1;
    check("send_count", k, 8);
    check("send_cycles", sc, bp ? 22 : 8);
    if (chain) begin
      start = 1'b1; row_addr = next_addr;
    end
    #1;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", out_valid, 0);
    check("done_err", err, 0);
    @(negedge clk);
    start = 1'b0;
    if (!chain) begin
      #1;
      check("done_clear", done, 0);
      check("after_busy", busy, 0);
      check("after_read", mem_read, 0);
    end
  endtask

  initial begin
    int errs, err_idx, dones;
    rst = 1'b1; start = 1'b0; row_addr = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_read", mem_read, 0);
    check("rst_addr", mem_address, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // zero wait, latency 1
    run_row(4'h5, 64'h0807060504030201, 0, 1, 0, 1, 0, 4'h0);
    // waitrequest stall, latency 2
    run_row(4'h9, 64'hDEADBEEF_CAFEF00D, 3, 2, 0, 1, 0, 4'h0);
    // backpressure 1,0,0 with stray start and readdatavalid
    run_row(4'h3, 64'h1122334455667788, 0, 1, 1, 1, 0, 4'h0);
    // zero-latency slave, then back-to-back start to address 2
    run_row(4'h7, 64'h0123456789ABCDEF, 1, 0, 0, 1, 1, 4'h2);
    run_row(4'h2, 64'hF0E1D2C3B4A59687, 0, 1, 0, 0, 0, 4'h0);

    // read timeout
    @(negedge clk);
    start = 1'b1; row_addr = 4'h4;
    @(negedge clk);
    start = 1'b0;
    #1 check("to_req", mem_read, 1);
    @(negedge clk);
    errs = 0; err_idx = -1; dones = 0;
    for (int w = 0; w <= TIMEOUT; w++) begin
      #1;
      if (err) begin errs++; err_idx = w; end
      if (done) dones++;
      @(negedge clk);
    end
    #1;
    check("to_err_count", errs, 1);
    check("to_err_cycle", err_idx, TIMEOUT);
    check("to_done_count", dones, 0);
    check("to_busy", busy, 0);
    check("to_err_clear", err, 0);
    @(negedge clk);
    mem_readdatavalid = 1'b1; mem_readdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_readdatavalid = 1'b0;
    #1;
    check("to_late_busy", busy, 0);
    check("to_late_valid", out_valid, 0);
    check("to_late_done", done, 0);

    // reset in SEND after 3 bytes
    @(negedge clk);
    start = 1'b1; row_addr = 4'h6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    mem_readdatavalid = 1'b1; mem_readdata = 64'hA1B2C3D4E5F60718;
    @(negedge clk);
    mem_readdatavalid = 1'b0;
    #1 check("mid_b0", out_data, 8'hA1);
    @(negedge clk);
    #1 check("mid_b1", out_data, 8'hB2);
    @(negedge clk);
    #1 check("mid_b2", out_data, 8'hC3);
    @(negedge clk);
    out_ready = 1'b0;
    #1 check("mid_b3", out_data, 8'hD4);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_read", mem_read, 0);
    check("mid_rst_addr", mem_address, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    mem_readdatavalid = 1'b1;
    @(negedge clk);
    mem_readdatavalid = 1'b0;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", out_valid, 0);
    run_row(4'h6, 64'h8877665544332211, 0, 1, 0, 1, 0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
